uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//   UART receiver; the receive-side counterpart of baud_generator. Consumes the 1-cycle oversampling
//   strobe from baud_generator (BAUD_RATE*OVERSAMPLING_RATE), detects start bit, mid-bit samples an
//   8N1 frame LSB-first, hands each byte to downstream logic over a valid/ready handshake.
// PARAMETERS
//   OVERSAMPLING_RATE  8  ticks per bit; even, >= 4; must match baud_generator setting
//   DATA_BITS          8  data bits per frame (5..9)
//   PARITY_ODD         0  1 = odd, 0 = even parity; used only with UART_RX_PARITY_EN
// PORTS
//   clk_in           in   1          system clock (100 MHz nominal)
//   nrst_in          in   1          asynchronous active-low reset
//   baud_tick_in     in   1          1-cycle strobe from baud_generator, BAUD_RATE*OVERSAMPLING_RATE
//   rx_in            in   1          serial line, asynchronous, idle high
//   data_out         out  DATA_BITS  received byte, stable while valid_out=1
//   valid_out        out  1          byte available; held until ready_in
//   ready_in         in   1          consumer accepts when valid_out && ready_in at clk_in edge
//   frame_err_out    out  1          1-cycle pulse: stop bit sampled 0
//   overrun_err_out  out  1          1-cycle pulse: byte completed while buffer full
//   parity_err_out   out  1          1-cycle pulse: parity mismatch (tied 0 without macro)
// BEHAVIOUR
//   Reset (async, nrst_in=0): state IDLE, counters 0, sync flops 1; data_out=0, all valid/err outputs 0.
//   rx_in passes 2-FF synchronizer (uart_rx_sync) -> rx_s; 2 clk_in cycles latency, reset value 1.
//   Tick counter tcnt [$clog2(OVERSAMPLING_RATE)-1:0] and bit counter advance only on baud_tick_in.
//   FSM (states in uart_pkg::rx_state_t):
//     IDLE   : rx_s==0 on a tick -> START, tcnt=0.
//     START  : at tcnt==OVERSAMPLING_RATE/2-1 sample rx_s; 0 -> DATA, tcnt=0, bitcnt=0;
//              1 -> IDLE (glitch rejected, no error flagged).
//     DATA   : on tcnt==OVERSAMPLING_RATE-1 sample rx_s into shift reg (LSB first), tcnt wraps to 0;
//              after DATA_BITS samples -> STOP (or PARITY when macro defined).
//     STOP   : at next mid-bit sample: 1 -> byte complete; 0 -> frame_err_out pulse, byte dropped.
//              Either way -> IDLE immediately (half-bit early, permits back-to-back frames).
//   Output buffer (1 entry): on byte complete in cycle N, data_out/valid_out update at edge N+1.
//     valid_out=1 & !ready_in at completion -> overrun_err_out pulse, old byte kept, new dropped.
//     valid_out=1 & ready_in same cycle as completion -> new byte loaded, valid_out stays 1, no error.
//     ready_in with valid_out=0 ignored. data_out unchanged after acceptance (not cleared).
//   Error pulses are exactly one clk_in cycle, independent of the handshake.
//   No tick for long periods: FSM holds state; reset mid-frame aborts frame, no output.
// CONFIGURATION
//   `UART_RX_PARITY_EN defined: PARITY state between DATA and STOP, one bit time, sample compared to
//     XOR(data)^PARITY_ODD; mismatch -> parity_err_out pulse, byte dropped, STOP still checked.
//   Not defined: no PARITY state, frame is 1+DATA_BITS+1 bits, parity_err_out tied 0.
// STRUCTURE
//   uart_pkg: rx_state_t enum {IDLE,START,DATA,PARITY,STOP}; UART_OVERSAMPLING_DEFAULT=8.
//   Sub-module uart_rx_sync: 2-FF synchronizer, async reset to 1, shared with future uart_tx loopback.
// TESTING (BAUD_RATE=230400, CLOCK_IN=100 MHz, OVERSAMPLING_RATE=8, bit time 4340 ns, real baud_generator)
//   1. Send 0x55, stop=1, ready_in=1 -> valid_out 1 cycle, data_out=0x55, no error pulses.
//   2. rx_in low 1000 ns then high -> no valid_out, no frame_err_out, FSM back in IDLE.
//   3. Send 0xA3 with stop=0 -> frame_err_out one pulse, valid_out stays 0.
//   4. ready_in=0, send 0x11 then 0x22 -> data_out=0x11 held, overrun_err_out pulse at 0x22 stop;
//      raise ready_in -> valid_out drops next cycle.
//   5. Assert nrst_in after 3rd data bit of 0xFF -> outputs 0 at once; next frame 0x0F received exactly.
//   6. With UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 parity=1 -> valid 0x07; parity=0 -> parity_err_out pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive path (and the planned transmitter).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int UART_OVERSAMPLING_DEFAULT = 8;

  // Expected parity bit for up to 9 data bits; unused upper bits must be zero.
  function automatic logic parity_of(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk_in,
  input  logic nrst_in,
  input  logic d_in,
  output logic q_out
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_in;
      sync_q <= meta_q;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with a one-entry valid/ready output buffer.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLING_RATE = UART_OVERSAMPLING_DEFAULT,
  parameter int DATA_BITS         = 8,
  parameter int PARITY_ODD        = 0
) (
  input  logic                 clk_in,
  input  logic                 nrst_in,
  input  logic                 baud_tick_in,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 frame_err_out,
  output logic                 overrun_err_out,
  output logic                 parity_err_out
);

  localparam int TW = $clog2(OVERSAMPLING_RATE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLING_RATE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLING_RATE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 complete_s;
  rx_state_t            state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_err_q, overrun_err_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
`else
  logic                 unused_parity_odd_s;
  assign unused_parity_odd_s = (PARITY_ODD != 0);
`endif

  uart_rx_sync u_sync (
    .clk_in (clk_in),
    .nrst_in(nrst_in),
    .d_in   (rx_in),
    .q_out  (rx_s)
  );

  // Frame FSM, bit sampling and output buffer next-state logic.
  always_comb begin
    state_d       = state_q;
    tcnt_d        = tcnt_q;
    bitcnt_d      = bitcnt_q;
    shift_d       = shift_q;
    data_d        = data_q;
    valid_d       = valid_q;
    complete_s    = 1'b0;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d     = par_bad_q;
    parity_err_d  = 1'b0;
`endif
    if (baud_tick_in) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            tcnt_d  = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
        START: begin
          if (tcnt_q == T_MID) begin
            tcnt_d   = '0;
            bitcnt_d = '0;
            state_d  = rx_s ? IDLE : DATA;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        DATA: begin
          if (tcnt_q == T_LAST) begin
            tcnt_d   = '0;
            shift_d  = {rx_s, shift_q[DATA_BITS-1:1]};
            bitcnt_d = bitcnt_q + BW'(1);
`ifdef UART_RX_PARITY_EN
            state_d  = (bitcnt_q == B_LAST) ? PARITY : DATA;
`else
            state_d  = (bitcnt_q == B_LAST) ? STOP : DATA;
`endif
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tcnt_q == T_LAST) begin
            tcnt_d       = '0;
            par_bad_d    = (rx_s != parity_of(9'(shift_q), PARITY_ODD != 0));
            parity_err_d = par_bad_d;
            state_d      = STOP;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
`endif
        STOP: begin
          // Leave at mid-stop so a back-to-back start edge is not missed.
          if (tcnt_q == T_LAST) begin
            tcnt_d  = '0;
            state_d = IDLE;
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              complete_s = !par_bad_q;
`else
              complete_s = 1'b1;
`endif
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          tcnt_d  = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (valid_q && ready_in) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (complete_s) begin
      if (valid_q && !ready_in) begin
        overrun_err_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        data_d  = shift_q;
      end
    end else begin
      overrun_err_d = 1'b0;
    end
  end

  // State, counters, buffer and error pulse registers.
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q       <= IDLE;
      tcnt_q        <= '0;
      bitcnt_q      <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      tcnt_q        <= tcnt_d;
      bitcnt_q      <= bitcnt_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= par_bad_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign data_out        = data_q;
  assign valid_out       = valid_q;
  assign frame_err_out   = frame_err_q;
  assign overrun_err_out = overrun_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_out  = parity_err_q;
`else
  assign parity_err_out  = 1'b0;
`endif

endmodule
